instruction_sequencer: RTL

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/seq_pkg.sv | 131 +++++++++++++
 rtl/seq_decoder.sv | 115 +++++++++++
 rtl/instruction_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the instruction sequencer.
//   - seq_state_t    : sequencer state encoding
//   - OP_*           : opcode constants (opcode lives in IROut[15:12])
//   - alu_fun_for()  : opcode-to-ALU_FunSel table for ALU ops 0x0-0x7
//   - FUN_*          : RF/ARF function-select encodings
//   - ARF_*          : ARF register indices and one-hot write enables
//   - MUXA_* / MUXB_*: datapath mux select encodings
//   - ctrl_t         : the full control vector, CTRL_IDLE its idle value
// Optional feature macro: SEQ_STORE_EN (ST instruction and state EXEC2).
package seq_pkg;

    typedef enum logic [2:0] {
        FETCH_L = 3'd0,
        FETCH_H = 3'd1,
        DECODE  = 3'd2,
        EXEC    = 3'd3,
`ifdef SEQ_STORE_EN
        EXEC2   = 3'd4,
`endif
        HALT    = 3'd5
    } seq_state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_ORR  = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_LSL  = 4'h5;
    localparam logic [3:0] OP_LSR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_MOVI = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_BRA  = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_ST   = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // ALU function codes
    localparam logic [4:0] ALU_PASS_A = 5'h00;
    localparam logic [4:0] ALU_NOT    = 5'h02;
    localparam logic [4:0] ALU_ADD    = 5'h04;
    localparam logic [4:0] ALU_SUB    = 5'h06;
    localparam logic [4:0] ALU_AND    = 5'h07;
    localparam logic [4:0] ALU_ORR    = 5'h08;
    localparam logic [4:0] ALU_XOR    = 5'h09;
    localparam logic [4:0] ALU_LSL    = 5'h0B;
    localparam logic [4:0] ALU_LSR    = 5'h0C;

    // RF / ARF function selects
    localparam logic [2:0] FUN_DEC  = 3'd0;
    localparam logic [2:0] FUN_INC  = 3'd1;
    localparam logic [2:0] FUN_LOAD = 3'd2;
    localparam logic [2:0] FUN_CLR  = 3'd3;

    // ARF register indices (used for OutC/OutD selects)
    localparam logic [1:0] ARF_PC = 2'd0;
    localparam logic [1:0] ARF_AR = 2'd1;
    localparam logic [1:0] ARF_SP = 2'd2;

    // ARF write enables are one bit per register, bit position = index
    localparam logic [2:0] ARF_SEL_PC = 3'b001;
    localparam logic [2:0] ARF_SEL_AR = 3'b010;

    localparam logic [1:0] MUXA_ALUOUT = 2'd0;
    localparam logic [1:0] MUXA_MEM    = 2'd2;
    localparam logic [1:0] MUXA_IROUT  = 2'd3;
    localparam logic [1:0] MUXB_IROUT  = 2'd3;

    typedef struct packed {
        logic [2:0] rf_outa_sel;
        logic [2:0] rf_outb_sel;
        logic [2:0] rf_fun_sel;
        logic [3:0] rf_reg_sel;
        logic [3:0] rf_scr_sel;
        logic [4:0] alu_fun_sel;
        logic       alu_wf;
        logic [1:0] arf_outc_sel;
        logic [1:0] arf_outd_sel;
        logic [2:0] arf_fun_sel;
        logic [2:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_write;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
        logic       halted;
    } ctrl_t;

    // Nothing enabled, memory deselected (Mem_CS is active-low)
    localparam ctrl_t CTRL_IDLE = '{
        rf_outa_sel:  3'd0,
        rf_outb_sel:  3'd0,
        rf_fun_sel:   3'd0,
        rf_reg_sel:   4'd0,
        rf_scr_sel:   4'd0,
        alu_fun_sel:  5'd0,
        alu_wf:       1'b0,
        arf_outc_sel: 2'd0,
        arf_outd_sel: 2'd0,
        arf_fun_sel:  3'd0,
        arf_reg_sel:  3'd0,
        ir_lh:        1'b0,
        ir_write:     1'b0,
        mem_wr:       1'b0,
        mem_cs:       1'b1,
        mux_a_sel:    2'd0,
        mux_b_sel:    2'd0,
        mux_c_sel:    1'b0,
        halted:       1'b0
    };

    function automatic logic [4:0] alu_fun_for(input logic [2:0] op);
        logic [4:0] fun;
        case (op)
            3'd0:    fun = ALU_ADD;
            3'd1:    fun = ALU_SUB;
            3'd2:    fun = ALU_AND;
            3'd3:    fun = ALU_ORR;
            3'd4:    fun = ALU_XOR;
            3'd5:    fun = ALU_LSL;
            3'd6:    fun = ALU_LSR;
            default: fun = ALU_NOT;
        endcase
        return fun;
    endfunction

endpackage

// File: rtl/seq_decoder.sv
// seq_decoder: purely combinational control decoder.
// Ports:
//   state  : current sequencer state
//   ir     : instruction register (opcode[15:12], Rd[11:10], Rs[9:8], S[7])
//   flags  : ALU flags {Z,C,N,O}; only Z (bit 3) is consulted
//   ctrl   : full control vector for the datapath
// Optional feature macro: SEQ_STORE_EN (ST decode and EXEC2 outputs).
module seq_decoder
    import seq_pkg::*;
(
    input  seq_state_t  state,
    input  logic [15:0] ir,
    input  logic [3:0]  flags,
    output ctrl_t       ctrl
);

    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       s_bit;
    logic       flag_z;
    logic       unused_bits;

    assign opcode = ir[15:12];
    assign rd     = ir[11:10];
    assign rs     = ir[9:8];
    assign s_bit  = ir[7];
    assign flag_z = flags[3];
    // imm8 travels through the datapath muxes, never through this decoder
    assign unused_bits = ^{ir[6:0], flags[2:0]};

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            FETCH_L, FETCH_H: begin
                ctrl.mem_cs       = 1'b0;
                ctrl.mem_wr       = 1'b0;
                ctrl.arf_outd_sel = ARF_PC;
                ctrl.ir_write     = 1'b1;
                ctrl.ir_lh        = (state == FETCH_H);
                ctrl.arf_reg_sel  = ARF_SEL_PC;
                ctrl.arf_fun_sel  = FUN_INC;
            end
            EXEC: begin
                if (!opcode[3]) begin
                    ctrl.rf_outa_sel = {1'b0, rd};
                    ctrl.rf_outb_sel = {1'b0, rs};
                    ctrl.alu_fun_sel = alu_fun_for(opcode[2:0]);
                    ctrl.alu_wf      = s_bit;
                    ctrl.mux_a_sel   = MUXA_ALUOUT;
                    ctrl.rf_reg_sel  = 4'b0001 << rd;
                    ctrl.rf_fun_sel  = FUN_LOAD;
                end else begin
                    case (opcode)
                        OP_MOVI: begin
                            ctrl.mux_a_sel  = MUXA_IROUT;
                            ctrl.rf_reg_sel = 4'b0001 << rd;
                            ctrl.rf_fun_sel = FUN_LOAD;
                        end
                        OP_LD: begin
                            ctrl.mem_cs       = 1'b0;
                            ctrl.mem_wr       = 1'b0;
                            ctrl.arf_outd_sel = ARF_AR;
                            ctrl.mux_a_sel    = MUXA_MEM;
                            ctrl.rf_reg_sel   = 4'b0001 << rd;
                            ctrl.rf_fun_sel   = FUN_LOAD;
                        end
                        OP_BRA, OP_BEQ, OP_BNE: begin
                            ctrl.mux_b_sel = MUXB_IROUT;
                            // PC is only written when the branch is taken
                            if ((opcode == OP_BRA) ||
                                (opcode == OP_BEQ && flag_z) ||
                                (opcode == OP_BNE && !flag_z)) begin
                                ctrl.arf_reg_sel = ARF_SEL_PC;
                                ctrl.arf_fun_sel = FUN_LOAD;
                            end
                        end
`ifdef SEQ_STORE_EN
                        OP_ST: begin
                            // low byte of Rd goes out first
                            ctrl.rf_outa_sel  = {1'b0, rd};
                            ctrl.alu_fun_sel  = ALU_PASS_A;
                            ctrl.mux_c_sel    = 1'b0;
                            ctrl.mem_wr       = 1'b1;
                            ctrl.mem_cs       = 1'b0;
                            ctrl.arf_outd_sel = ARF_AR;
                            ctrl.arf_reg_sel  = ARF_SEL_AR;
                            ctrl.arf_fun_sel  = FUN_INC;
                        end
`endif
                        default: ;
                    endcase
                end
            end
`ifdef SEQ_STORE_EN
            EXEC2: begin
                // high byte of Rd at the already-incremented AR
                ctrl.rf_outa_sel  = {1'b0, rd};
                ctrl.alu_fun_sel  = ALU_PASS_A;
                ctrl.mux_c_sel    = 1'b1;
                ctrl.mem_wr       = 1'b1;
                ctrl.mem_cs       = 1'b0;
                ctrl.arf_outd_sel = ARF_AR;
                ctrl.arf_reg_sel  = ARF_SEL_AR;
                ctrl.arf_fun_sel  = FUN_INC;
            end
`endif
            HALT: begin
                ctrl.halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/decode/execute control sequencer.
// Ports:
//   Clock, Reset (synchronous, active-low)
//   IROut[15:0] instruction register, Flags[3:0] ALU flags {Z,C,N,O}
//   RF_*   register-file controls, ALU_* ALU controls,
//   ARF_*  address-register-file controls, IR_LH/IR_Write, Mem_WR/Mem_CS,
//   MuxASel/MuxBSel/MuxCSel datapath selects, Halted.
// Holds only the state register and next-state logic; all output decoding
// lives in seq_decoder.
// Optional feature macro: SEQ_STORE_EN (ST instruction with EXEC2 state).
module instruction_sequencer
    import seq_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  Flags,
    output logic [2:0]  RF_OutASel,
    output logic [2:0]  RF_OutBSel,
    output logic [2:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  RF_ScrSel,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Write,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted
);

    seq_state_t state_q;
    seq_state_t state_d;
    ctrl_t      dec_ctrl;
    ctrl_t      ctrl;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= FETCH_L;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_L: state_d = FETCH_H;
            FETCH_H: state_d = DECODE;
            DECODE:  state_d = (IROut[15:12] == OP_HLT) ? HALT : EXEC;
`ifdef SEQ_STORE_EN
            EXEC:    state_d = (IROut[15:12] == OP_ST) ? EXEC2 : FETCH_L;
            EXEC2:   state_d = FETCH_L;
`else
            EXEC:    state_d = FETCH_L;
`endif
            HALT:    state_d = HALT;
            default: state_d = FETCH_L;
        endcase
    end

    seq_decoder u_decoder (
        .state (state_q),
        .ir    (IROut),
        .flags (Flags),
        .ctrl  (dec_ctrl)
    );

    // Reset gates the outputs combinationally so no write can escape in
    // the cycle that abandons an instruction.
    always_comb begin
        ctrl = dec_ctrl;
        if (!Reset) begin
            ctrl = CTRL_IDLE;
        end
    end

    assign RF_OutASel  = ctrl.rf_outa_sel;
    assign RF_OutBSel  = ctrl.rf_outb_sel;
    assign RF_FunSel   = ctrl.rf_fun_sel;
    assign RF_RegSel   = ctrl.rf_reg_sel;
    assign RF_ScrSel   = ctrl.rf_scr_sel;
    assign ALU_FunSel  = ctrl.alu_fun_sel;
    assign ALU_WF      = ctrl.alu_wf;
    assign ARF_OutCSel = ctrl.arf_outc_sel;
    assign ARF_OutDSel = ctrl.arf_outd_sel;
    assign ARF_FunSel  = ctrl.arf_fun_sel;
    assign ARF_RegSel  = ctrl.arf_reg_sel;
    assign IR_LH       = ctrl.ir_lh;
    assign IR_Write    = ctrl.ir_write;
    assign Mem_WR      = ctrl.mem_wr;
    assign Mem_CS      = ctrl.mem_cs;
    assign MuxASel     = ctrl.mux_a_sel;
    assign MuxBSel     = ctrl.mux_b_sel;
    assign MuxCSel     = ctrl.mux_c_sel;
    assign Halted      = ctrl.halted;

endmodule
